instr_fetcher: RTL and testbench

// - Per-core instruction fetch stage. It sits directly downstream of the per-thread PC logic,

---
 rtl/instr_fetcher.sv | 127 ++++++++++++
 tb/tb_instr_fetcher.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetcher.sv
// Instruction fetch stage: one program-memory read per FETCH entry, result held for decode.
// Latency: FETCH seen -> FETCHED in 2 edges when ready is already high (1 edge on a cache hit).
// Backpressure: the request is held with a stable address until mem_read_ready; it is never cancelled.
// Optional one-entry instruction cache enabled by defining FETCH_CACHE_EN.
module instr_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             cache_flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_FETCHING = 3'b001,
    S_FETCHED  = 3'b010
  } state_t;

  state_t                             r_state;
  logic                               r_valid;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   r_addr;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   r_instr;

  logic                               w_fetch_req;
  logic                               w_complete;
  logic                               w_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   w_hit_instr;

  assign w_fetch_req = (core_state == CORE_FETCH);
  // Valid is always high in FETCHING, so ready outside FETCHING never completes anything.
  assign w_complete  = (r_state == S_FETCHING) && mem_read_ready;

`ifdef FETCH_CACHE_EN
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   r_tag_pc;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   r_tag_instr;
  logic                               r_tag_valid;

  // A same-edge flush forces the lookup to miss.
  assign w_hit       = r_tag_valid && !cache_flush && (current_pc == r_tag_pc);
  assign w_hit_instr = r_tag_instr;

  // Every memory completion refills the single entry; flush beats a same-edge fill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag_pc    <= '0;
      r_tag_instr <= '0;
      r_tag_valid <= 1'b0;
    end else begin
      if (w_complete) begin
        r_tag_pc    <= r_addr;
        r_tag_instr <= mem_read_data;
      end
      if (cache_flush) begin
        r_tag_valid <= 1'b0;
      end else if (w_complete) begin
        r_tag_valid <= 1'b1;
      end
    end
  end
`else
  // Without the cache every fetch goes to memory and the flush input has no effect.
  logic w_unused_flush;
  assign w_unused_flush = cache_flush;
  assign w_hit          = 1'b0;
  assign w_hit_instr    = '0;
`endif

  // Fetch FSM with registered request, address and instruction outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_instr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fetch_req) begin
            if (w_hit) begin
              r_instr <= w_hit_instr;
              r_state <= S_FETCHED;
            end else begin
              r_valid <= 1'b1;
              r_addr  <= current_pc;
              r_state <= S_FETCHING;
            end
          end
        end
        S_FETCHING: begin
          // Address stays as latched at request time; PC and scheduler changes are ignored.
          if (mem_read_ready) begin
            r_instr <= mem_read_data;
            r_valid <= 1'b0;
            r_state <= S_FETCHED;
          end
        end
        S_FETCHED: begin
          if (core_state == CORE_DECODE) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read_valid   = r_valid;
  assign mem_read_address = r_addr;
  assign fetcher_state    = r_state;
  assign instruction      = r_instr;

endmodule

// File: tb/tb_instr_fetcher.sv
// Bench for instr_fetcher: directed fetches, expected requests/instructions queued at issue time,
// a negedge monitor pops and compares whenever a request or a FETCHED entry appears.
module tb_instr_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        cache_flush;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  exp_addr_q[$];
  logic [15:0] exp_instr_q[$];
  int          exp_vlen_q[$];

  always #5 clk = ~clk;

  instr_fetcher #(
    .PROGRAM_MEM_ADDR_BITS(8),
    .PROGRAM_MEM_DATA_BITS(16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .core_state       (core_state),
    .current_pc       (current_pc),
    .cache_flush      (cache_flush),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .fetcher_state    (fetcher_state),
    .instruction      (instruction)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event seen with no expected entry queued", name);
  endtask

  // Monitor / scoreboard.
  logic       prev_v;
  logic [2:0] prev_s;
  int         vcnt;
  logic [7:0] req_addr;

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      prev_v = 1'b0;
      prev_s = 3'b000;
      vcnt   = 0;
    end else begin
      if (mem_read_valid) begin
        if (!prev_v) begin
          if (exp_addr_q.size() == 0) report_fail("unexpected_request");
          else check("req_addr", {24'd0, mem_read_address}, {24'd0, exp_addr_q.pop_front()});
          req_addr = mem_read_address;
          vcnt     = 0;
        end else begin
          check("addr_stable", {24'd0, mem_read_address}, {24'd0, req_addr});
        end
        vcnt++;
      end else if (prev_v) begin
        if (exp_vlen_q.size() == 0) report_fail("unexpected_valid_fall");
        else check("valid_cycles", vcnt, exp_vlen_q.pop_front());
      end
      if (fetcher_state == 3'b010 && prev_s != 3'b010) begin
        if (exp_instr_q.size() == 0) report_fail("unexpected_fetched");
        else check("fetched_instr", {16'd0, instruction}, {16'd0, exp_instr_q.pop_front()});
      end
      prev_v = mem_read_valid;
      prev_s = fetcher_state;
    end
  end

  // Full memory fetch: request, wait_cyc cycles with ready low, completion, then decode back to IDLE.
  // Called and returns at posedge+2.
  task automatic do_fetch(input logic [7:0] pc, input logic [15:0] data, input int wait_cyc,
                          input bit wiggle_pc);
    exp_addr_q.push_back(pc);
    exp_instr_q.push_back(data);
    exp_vlen_q.push_back(wait_cyc + 1);
    core_state = 3'b001;
    current_pc = pc;
    @(posedge clk); #2;
    core_state = 3'b000;
    check("valid_after_request", {31'd0, mem_read_valid}, 32'd1);
    check("state_fetching", {29'd0, fetcher_state}, 32'd1);
    if (wiggle_pc) current_pc = pc + 8'd1;
    repeat (wait_cyc) begin
      @(posedge clk); #2;
    end
    check("addr_before_complete", {24'd0, mem_read_address}, {24'd0, pc});
    mem_read_ready = 1'b1;
    mem_read_data  = data;
    @(posedge clk); #2;
    mem_read_ready = 1'b0;
    mem_read_data  = 16'hDEAD;
    check("state_fetched", {29'd0, fetcher_state}, 32'd2);
    check("valid_dropped", {31'd0, mem_read_valid}, 32'd0);
    check("instr_direct", {16'd0, instruction}, {16'd0, data});
    core_state = 3'b010;
    @(posedge clk); #2;
    core_state = 3'b000;
    check("idle_after_decode", {29'd0, fetcher_state}, 32'd0);
    check("instr_held", {16'd0, instruction}, {16'd0, data});
  endtask

  initial begin
    reset          = 1'b0;
    core_state     = 3'b000;
    current_pc     = 8'h00;
    cache_flush    = 1'b0;
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0000;
    #1;
    check("rst_valid", {31'd0, mem_read_valid}, 32'd0);
    check("rst_addr", {24'd0, mem_read_address}, 32'd0);
    check("rst_state", {29'd0, fetcher_state}, 32'd0);
    check("rst_instr", {16'd0, instruction}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;

    // Basic fetch at 0x05: valid high exactly 3 cycles, PC moves to 0x06 mid-request.
    do_fetch(8'h05, 16'h3012, 2, 1'b1);

    // Ready pulse while idle must be ignored.
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hBEEF;
    @(posedge clk); #2;
    mem_read_ready = 1'b0;
    check("idle_ready_state", {29'd0, fetcher_state}, 32'd0);
    check("idle_ready_valid", {31'd0, mem_read_valid}, 32'd0);
    check("idle_ready_instr", {16'd0, instruction}, 32'h3012);

    // Reset during an outstanding request with ready low.
    exp_addr_q.push_back(8'h09);
    core_state = 3'b001;
    current_pc = 8'h09;
    @(posedge clk); #2;
    core_state = 3'b000;
    check("pre_reset_valid", {31'd0, mem_read_valid}, 32'd1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("midrst_valid", {31'd0, mem_read_valid}, 32'd0);
    check("midrst_state", {29'd0, fetcher_state}, 32'd0);
    check("midrst_addr", {24'd0, mem_read_address}, 32'd0);
    check("midrst_instr", {16'd0, instruction}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;

    // Minimum latency fetch at 0x07, then the maximum PC.
    do_fetch(8'h07, 16'h1234, 0, 1'b0);
    do_fetch(8'hFF, 16'hF000, 1, 1'b1);

`ifdef FETCH_CACHE_EN
    // Miss fills the cache, repeat is a 1-edge hit with no request, flush forces memory again.
    do_fetch(8'h05, 16'h3012, 0, 1'b0);
    exp_instr_q.push_back(16'h3012);
    core_state = 3'b001;
    current_pc = 8'h05;
    @(posedge clk); #2;
    core_state = 3'b000;
    check("hit_state", {29'd0, fetcher_state}, 32'd2);
    check("hit_no_valid", {31'd0, mem_read_valid}, 32'd0);
    check("hit_instr", {16'd0, instruction}, 32'h3012);
    core_state = 3'b010;
    @(posedge clk); #2;
    core_state = 3'b000;
    cache_flush = 1'b1;
    @(posedge clk); #2;
    cache_flush = 1'b0;
    do_fetch(8'h05, 16'h3012, 1, 1'b0);
`else
    // Without the cache a repeated PC still goes to memory.
    do_fetch(8'h05, 16'h3012, 0, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #2;
    check("queues_drained", exp_addr_q.size() + exp_instr_q.size() + exp_vlen_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
